// File: rtl/pc_sequencer.sv
// Multicycle PC sequencer: owns the architectural PC, fetches one instruction at a time,
// fires a one-cycle execute enable and picks the next PC or a trap redirect on completion.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_resp_valid,
  output logic        ifu_resp_ready,
  input  logic [31:0] ifu_resp_inst,
  input  logic        ifu_resp_err,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        exu_done,
  input  logic        halt,
  input  logic        jump_flag,
  input  logic        branch_flag,
  input  logic        is_mret,
  input  logic        is_ecall,
  input  logic [31:0] exu_res,
  input  logic [31:0] branch_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] pc,
  output logic [31:0] snpc,
  output logic        commit,
  output logic        trap_take,
  output logic [31:0] trap_epc,
  output logic [3:0]  trap_cause,
  output logic        halted
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StExec, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        commit_q, commit_d;
  logic        trap_take_q, trap_take_d;
  logic [31:0] trap_epc_q, trap_epc_d;
  logic [3:0]  trap_cause_q, trap_cause_d;
  logic [31:0] tgt;
  logic        tgt_is_ctl;

  // Only jump/branch targets are subject to the alignment check.
  always_comb begin
    tgt        = snpc;
    tgt_is_ctl = 1'b0;
    if (is_ecall) begin
      tgt = mtvec;
    end else if (is_mret) begin
      tgt = mepc;
    end else if (jump_flag) begin
      tgt        = exu_res;
      tgt_is_ctl = 1'b1;
    end else if (branch_flag) begin
      tgt        = branch_pc;
      tgt_is_ctl = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    commit_d     = 1'b0;
    trap_take_d  = 1'b0;
    trap_epc_d   = trap_epc_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (ifu_req_ready) state_d = StWait;
      StWait: begin
        if (ifu_resp_valid) begin
          if (ifu_resp_err) begin
            pc_d         = mtvec;
            trap_take_d  = 1'b1;
            trap_epc_d   = pc_q;
            trap_cause_d = 4'd1;
            state_d      = StFetch;
          end else begin
            inst_d       = ifu_resp_inst;
            inst_valid_d = 1'b1;
            state_d      = StExec;
          end
        end
      end
      StExec: begin
        if (exu_done) begin
          if (halt) begin
            commit_d = 1'b1;
            state_d  = StHalted;
          end else if (tgt_is_ctl && (tgt[1:0] != 2'b00)) begin
            pc_d         = mtvec;
            trap_take_d  = 1'b1;
            trap_epc_d   = pc_q;
            trap_cause_d = 4'd0;
            state_d      = StFetch;
          end else begin
            pc_d     = tgt;
            commit_d = 1'b1;
            state_d  = StFetch;
          end
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      commit_q     <= 1'b0;
      trap_take_q  <= 1'b0;
      trap_epc_q   <= 32'h0;
      trap_cause_q <= 4'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      commit_q     <= commit_d;
      trap_take_q  <= trap_take_d;
      trap_epc_q   <= trap_epc_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign ifu_req_valid  = (state_q == StFetch);
  assign ifu_req_addr   = pc_q;
  assign ifu_resp_ready = (state_q == StWait);
  assign inst           = inst_q;
  assign inst_valid     = inst_valid_q;
  assign pc             = pc_q;
  assign snpc           = pc_q + 32'd4;
  assign commit         = commit_q;
  assign trap_take      = trap_take_q;
  assign trap_epc       = trap_epc_q;
  assign trap_cause     = trap_cause_q;
  assign halted         = (state_q == StHalted);

endmodule
